motor_bridge_drv: RTL and testbench

Consumes the 4-bit motor command nibble {IN4,IN3,IN2,IN1} produced by the line-follow steering logic and drives a dual H-bridge: per-channel direction pins plus PWM enables.
- Channel A = {IN2,IN1}; channel B = {IN4,IN3}.
- Adds input synchronisation, soft-start duty ramp, direction-reversal dead time and an optional active brake.
- Sits between the steering logic and the board's bridge pins.

---
 rtl/motor_bridge_drv.sv | 234 +++++++++++++++++++++++
 tb/tb_motor_bridge_drv.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_bridge_drv.sv
// motor_bridge_drv: turns the steering logic's 4-bit motor command into
// dual H-bridge direction pins plus PWM enables, with input synchronisation,
// soft-start duty ramp, reversal dead time and an optional active brake.
// Optional feature macro: MOTOR_BRAKE_EN (define to enable the 11 = brake
// decode and the BRAKE state; undefined, 11 is treated as coast).

// One bridge channel. Forward and reverse are symmetric, so the channel only
// needs to know the two-bit pin pattern to drive; the mirrored decode of
// channel B falls out of latching the raw pattern.
module motor_bridge_chan #(
  parameter int PWM_W     = 8,
  parameter int DUTY_MAX  = 200,
  parameter int RAMP_STEP = 4,
  parameter int RAMP_DIV  = 1000,
  parameter int DEAD_CYC  = 50
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_cmd,
  input  logic [PWM_W-1:0] i_cnt,
  output logic [1:0]       o_pair,
  output logic             o_en,
  output logic             o_done
);

  localparam int DW  = PWM_W + 1;
  localparam int TW  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DCW = $clog2(DEAD_CYC + 1);

  localparam logic [DW-1:0]  DUTY_CEIL  = DW'(DUTY_MAX);
  localparam logic [DW:0]    STEP_EXT   = (DW + 1)'(RAMP_STEP);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(RAMP_DIV - 1);
  localparam logic [DCW-1:0] DEAD_LOAD  = DCW'(DEAD_CYC);
  localparam logic [DCW-1:0] DEAD_ONE   = DCW'(1);

`ifdef MOTOR_BRAKE_EN
  localparam bit BRAKE_EN = 1'b1;
`else
  localparam bit BRAKE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {COAST, DRIVE, DEAD, BRAKE} state_t;

  state_t         r_state;
  logic [1:0]     r_dir;
  logic [DW-1:0]  r_duty;
  logic [TW-1:0]  r_timer;
  logic [DCW-1:0] r_dead;

  logic           w_isDrive;
  logic           w_isBrk;
  logic           w_isCoast;
  logic [DW:0]    w_sum;
  logic [DW-1:0]  w_dutyNext;

  // Command decode plus the saturating next-duty value used on a ramp tick.
  always_comb begin
    w_isDrive  = (i_cmd == 2'b01) || (i_cmd == 2'b10);
    w_isBrk    = BRAKE_EN && (i_cmd == 2'b11);
    w_isCoast  = !w_isDrive && !w_isBrk;
    w_sum      = {1'b0, r_duty} + STEP_EXT;
    w_dutyNext = (w_sum > {1'b0, DUTY_CEIL}) ? DUTY_CEIL : w_sum[DW-1:0];
  end

  // Channel FSM with registered pin/enable outputs; leaving COAST and the end
  // of a dead window share the same "enter from command" decision.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= COAST;
      r_dir   <= 2'b00;
      r_duty  <= '0;
      r_timer <= '0;
      r_dead  <= '0;
      o_pair  <= 2'b00;
      o_en    <= 1'b0;
    end else begin
      case (r_state)
        COAST, DEAD: begin
          if (r_state == DEAD && r_dead != DEAD_ONE) begin
            r_dead <= r_dead - DEAD_ONE;
            o_pair <= 2'b00;
            o_en   <= 1'b0;
            r_duty <= '0;
          end else if (w_isDrive) begin
            r_state <= DRIVE;
            r_dir   <= i_cmd;
            o_pair  <= i_cmd;
            o_en    <= 1'b0;
            r_duty  <= '0;
            r_timer <= '0;
          end else if (w_isBrk) begin
            r_state <= BRAKE;
            o_pair  <= 2'b11;
            o_en    <= 1'b1;
            r_duty  <= '0;
          end else begin
            r_state <= COAST;
            o_pair  <= 2'b00;
            o_en    <= 1'b0;
            r_duty  <= '0;
          end
        end
        DRIVE: begin
          if (i_cmd == r_dir) begin
            o_pair <= r_dir;
            o_en   <= ({1'b0, i_cnt} < r_duty);
            if (r_timer == TIMER_LAST) begin
              r_timer <= '0;
              r_duty  <= w_dutyNext;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end else if (w_isCoast) begin
            r_state <= COAST;
            o_pair  <= 2'b00;
            o_en    <= 1'b0;
            r_duty  <= '0;
          end else begin
            r_state <= DEAD;
            r_dead  <= DEAD_LOAD;
            o_pair  <= 2'b00;
            o_en    <= 1'b0;
            r_duty  <= '0;
          end
        end
        BRAKE: begin
          if (w_isDrive) begin
            r_state <= DEAD;
            r_dead  <= DEAD_LOAD;
            o_pair  <= 2'b00;
            o_en    <= 1'b0;
          end else if (w_isCoast) begin
            r_state <= COAST;
            o_pair  <= 2'b00;
            o_en    <= 1'b0;
          end else begin
            o_pair  <= 2'b11;
            o_en    <= 1'b1;
          end
          r_duty <= '0;
        end
        default: begin
          r_state <= COAST;
          o_pair  <= 2'b00;
          o_en    <= 1'b0;
          r_duty  <= '0;
        end
      endcase
    end
  end

  // Ramp complete flag straight from registered state and duty.
  always_comb begin
    o_done = (r_state == DRIVE) && (r_duty == DUTY_CEIL);
  end

endmodule

// Top level: synchroniser, shared PWM counter and the two channels.
module motor_bridge_drv #(
  parameter int PWM_W     = 8,
  parameter int DUTY_MAX  = 200,
  parameter int RAMP_STEP = 4,
  parameter int RAMP_DIV  = 1000,
  parameter int DEAD_CYC  = 50
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_motor,
  output logic [3:0] o_bridge_in,
  output logic       o_ena,
  output logic       o_enb,
  output logic [1:0] o_ramp_done
);

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [PWM_W-1:0] r_cnt;

  logic [1:0]       w_pairA;
  logic [1:0]       w_pairB;

  // Two-flop synchroniser for the possibly asynchronous command nibble.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= i_motor;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running PWM counter shared by both channels; wraps naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PWM_W'(1);
    end
  end

  motor_bridge_chan #(
    .PWM_W(PWM_W), .DUTY_MAX(DUTY_MAX), .RAMP_STEP(RAMP_STEP),
    .RAMP_DIV(RAMP_DIV), .DEAD_CYC(DEAD_CYC)
  ) u_chanA (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_cmd (r_sync2[1:0]),
    .i_cnt (r_cnt),
    .o_pair(w_pairA),
    .o_en  (o_ena),
    .o_done(o_ramp_done[0])
  );

  motor_bridge_chan #(
    .PWM_W(PWM_W), .DUTY_MAX(DUTY_MAX), .RAMP_STEP(RAMP_STEP),
    .RAMP_DIV(RAMP_DIV), .DEAD_CYC(DEAD_CYC)
  ) u_chanB (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_cmd (r_sync2[3:2]),
    .i_cnt (r_cnt),
    .o_pair(w_pairB),
    .o_en  (o_enb),
    .o_done(o_ramp_done[1])
  );

  // Channel pin pairs are already registered; just place them in motor order.
  always_comb begin
    o_bridge_in = {w_pairB, w_pairA};
  end

endmodule

// File: tb/tb_motor_bridge_drv.sv
// tb_motor_bridge_drv: directed scenarios plus randomized command streams
// for motor_bridge_drv, checked against a behavioural model of the bridge
// rules. Honours MOTOR_BRAKE_EN the same way as the design.
module tb_motor_bridge_drv;

  localparam int PWM_W     = 4;
  localparam int PERIOD    = 16;
  localparam int DUTY_MAX  = 12;
  localparam int RAMP_STEP = 4;
  localparam int RAMP_DIV  = 4;
  localparam int DEAD_CYC  = 3;

  localparam int M_COAST = 0;
  localparam int M_DRIVE = 1;
  localparam int M_DEAD  = 2;
  localparam int M_BRAKE = 3;

  localparam int K_COAST = 0;
  localparam int K_DRIVE = 1;
  localparam int K_BRK   = 2;

  logic       clk;
  logic       rst;
  logic [3:0] motor;
  logic [3:0] bridgeIn;
  logic       ena;
  logic       enb;
  logic [1:0] rampDone;

  int total = 0;
  int bad   = 0;

  logic [3:0] mS1;
  logic [3:0] mS2;
  int         mCnt;
  int         mMode [2];
  int         mAge  [2];
  int         mLeft [2];
  logic [1:0] mLat  [2];
  logic [1:0] mPair [2];
  logic       mEn   [2];

  motor_bridge_drv #(
    .PWM_W(PWM_W), .DUTY_MAX(DUTY_MAX), .RAMP_STEP(RAMP_STEP),
    .RAMP_DIV(RAMP_DIV), .DEAD_CYC(DEAD_CYC)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_motor    (motor),
    .o_bridge_in(bridgeIn),
    .o_ena      (ena),
    .o_enb      (enb),
    .o_ramp_done(rampDone)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls the stimulus.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic int cmdKind(input logic [1:0] c);
    if (c == 2'b01 || c == 2'b10) return K_DRIVE;
`ifdef MOTOR_BRAKE_EN
    if (c == 2'b11) return K_BRK;
`endif
    return K_COAST;
  endfunction

  // Duty follows directly from how long the channel has been driving.
  function automatic int modelDuty(input int ch);
    int d;
    if (mMode[ch] != M_DRIVE) return 0;
    d = (mAge[ch] / RAMP_DIV) * RAMP_STEP;
    if (d > DUTY_MAX) d = DUTY_MAX;
    return d;
  endfunction

  task automatic modelReset();
    mS1  = 4'b0000;
    mS2  = 4'b0000;
    mCnt = 0;
    for (int ch = 0; ch < 2; ch++) begin
      mMode[ch] = M_COAST;
      mAge[ch]  = 0;
      mLeft[ch] = 0;
      mLat[ch]  = 2'b00;
      mPair[ch] = 2'b00;
      mEn[ch]   = 1'b0;
    end
  endtask

  task automatic goCoast(input int ch);
    mMode[ch] = M_COAST;
    mPair[ch] = 2'b00;
    mEn[ch]   = 1'b0;
  endtask

  task automatic goDead(input int ch);
    mMode[ch] = M_DEAD;
    mLeft[ch] = DEAD_CYC;
    mPair[ch] = 2'b00;
    mEn[ch]   = 1'b0;
  endtask

  task automatic modelEnter(input int ch, input logic [1:0] c, input int kind);
    if (kind == K_DRIVE) begin
      mMode[ch] = M_DRIVE;
      mLat[ch]  = c;
      mAge[ch]  = 0;
      mPair[ch] = c;
      mEn[ch]   = 1'b0;
    end else if (kind == K_BRK) begin
      mMode[ch] = M_BRAKE;
      mPair[ch] = 2'b11;
      mEn[ch]   = 1'b1;
    end else begin
      goCoast(ch);
    end
  endtask

  // One clock edge of the reference: m is the motor value seen at this edge.
  task automatic modelEdge(input logic [3:0] m);
    logic [1:0] c;
    int kind;
    int duty;
    for (int ch = 0; ch < 2; ch++) begin
      c    = mS2[2*ch +: 2];
      kind = cmdKind(c);
      duty = modelDuty(ch);
      case (mMode[ch])
        M_COAST: modelEnter(ch, c, kind);
        M_DRIVE: begin
          if (c == mLat[ch]) begin
            mEn[ch] = (mCnt < duty);
            mAge[ch]++;
          end else if (kind == K_COAST) begin
            goCoast(ch);
          end else begin
            goDead(ch);
          end
        end
        M_DEAD: begin
          if (mLeft[ch] == 1) modelEnter(ch, c, kind);
          else mLeft[ch]--;
        end
        default: begin
          if (kind == K_DRIVE) goDead(ch);
          else if (kind == K_COAST) goCoast(ch);
        end
      endcase
    end
    mCnt = (mCnt + 1) % PERIOD;
    mS2  = mS1;
    mS1  = m;
  endtask

  task automatic compareAll();
    logic [1:0] expDone;
    for (int ch = 0; ch < 2; ch++)
      expDone[ch] = (mMode[ch] == M_DRIVE) && (modelDuty(ch) == DUTY_MAX);
    checkOutput("bridge", 8'(bridgeIn), 8'({mPair[1], mPair[0]}));
    checkOutput("ena", 8'(ena), 8'(mEn[0]));
    checkOutput("enb", 8'(enb), 8'(mEn[1]));
    checkOutput("done", 8'(rampDone), 8'(expDone));
  endtask

  // Hold motor for n cycles, checking every output after each edge.
  task automatic applyStimulus(input logic [3:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      motor = m;
      @(posedge clk);
      modelEdge(m);
      @(negedge clk);
      compareAll();
    end
  endtask

  int hiA;
  int hiB;
  int zeroA;
  int keepB;
  int segLen;
  logic [3:0] segVal;

  initial begin
    rst   = 1'b1;
    motor = 4'b0000;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_bridge", 8'(bridgeIn), 8'h00);
    checkOutput("rst_en", 8'({ena, enb}), 8'h00);
    checkOutput("rst_done", 8'(rampDone), 8'h00);
    rst = 1'b0;
    applyStimulus(4'b0000, 4);

    // Asynchronous reset while channel A drives.
    applyStimulus(4'b0001, 20);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_bridge", 8'(bridgeIn), 8'h00);
    checkOutput("arst_en", 8'({ena, enb}), 8'h00);
    checkOutput("arst_done", 8'(rampDone), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    applyStimulus(4'b0000, 5);

    // Forward ramp on both channels, with latency and high-time checks.
    applyStimulus(4'b1001, 2);
    checkOutput("lat2", 8'(bridgeIn), 8'h00);
    applyStimulus(4'b1001, 1);
    checkOutput("lat3", 8'(bridgeIn), 8'h09);
    applyStimulus(4'b1001, 40);
    hiA = 0;
    hiB = 0;
    for (int i = 0; i < PERIOD; i++) begin
      applyStimulus(4'b1001, 1);
      hiA += int'(ena);
      hiB += int'(enb);
    end
    checkOutput("hightimeA", 8'(hiA), 8'(DUTY_MAX));
    checkOutput("hightimeB", 8'(hiB), 8'(DUTY_MAX));
    checkOutput("ramp_full", 8'(rampDone), 8'h03);

    // Reversal of A at full duty; B must keep driving.
    zeroA = 0;
    keepB = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b1010, 1);
      if (bridgeIn[1:0] == 2'b00) zeroA++;
      if (bridgeIn[3:2] == 2'b10) keepB++;
    end
    checkOutput("rev_dead", 8'(zeroA), 8'(DEAD_CYC));
    checkOutput("rev_B", 8'(keepB), 8'd10);
    checkOutput("rev_pairA", 8'(bridgeIn[1:0]), 8'h2);

    // Command glitches back during the dead window.
    applyStimulus(4'b0001, 30);
    applyStimulus(4'b0010, 2);
    zeroA = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b0001, 1);
      if (bridgeIn[1:0] == 2'b00) zeroA++;
    end
    checkOutput("glitch_dead", 8'(zeroA), 8'(DEAD_CYC));
    checkOutput("glitch_pairA", 8'(bridgeIn[1:0]), 8'h1);

    // Coast and restart.
    applyStimulus(4'b1001, 40);
    applyStimulus(4'b0000, 6);
    checkOutput("coast_bridge", 8'(bridgeIn), 8'h00);
    checkOutput("coast_en", 8'({ena, enb}), 8'h00);
    applyStimulus(4'b1001, 4);
    checkOutput("restart_done", 8'(rampDone), 8'h00);

    // Brake request from coast.
    applyStimulus(4'b0000, 8);
    applyStimulus(4'b0011, 4);
    hiA = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b0011, 1);
      hiA += int'(ena);
    end
`ifdef MOTOR_BRAKE_EN
    checkOutput("brake_pair", 8'(bridgeIn[1:0]), 8'h3);
    checkOutput("brake_en", 8'(hiA), 8'd6);
`else
    checkOutput("brake_pair", 8'(bridgeIn[1:0]), 8'h0);
    checkOutput("brake_en", 8'(hiA), 8'd0);
`endif

    // Randomized command segments against the model.
    for (int s = 0; s < 150; s++) begin
      segVal = 4'($urandom_range(0, 15));
      segLen = int'($urandom_range(1, 30));
      applyStimulus(segVal, segLen);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
